// File: rtl/datapath_control_unit.sv
// Hardwired T-state sequencer driving every strobe of the 32-bit bus datapath.
// Optional SINGLE_STEP_EN adds a step input that releases one instruction per pulse from T0.
module datapath_control_unit #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic        hi_in,
  output logic        lo_in,
  output logic        hi_out,
  output logic        lo_out,
  output logic        zhigh_in,
  output logic        zlow_in,
  output logic        zhigh_out,
  output logic        zlow_out,
  output logic        pc_in,
  output logic        pc_out,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        mar_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        cse_out,
  output logic        md_mux_read,
  output logic [12:0] alu_sel,
  output logic        inc_pc,
  output logic        mem_read,
  output logic        mem_write,
  output logic        halted,
  output logic        timeout_err
);

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

  typedef struct packed {
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic        hi_in, lo_in, hi_out, lo_out;
    logic        zhigh_in, zlow_in, zhigh_out, zlow_out;
    logic        pc_in, pc_out, mdr_in, mdr_out, mar_in, ir_in, y_in, cse_out;
    logic        md_mux_read;
    logic [12:0] alu_sel;
    logic        inc_pc, mem_read, mem_write, halted, timeout_err;
  } ctl_t;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic          err;
  ctl_t          ctl, ctl_q;

  logic [4:0]  op;
  logic [15:0] ra_oh, rb_oh, rc_oh;
  logic [12:0] alu_op;
  logic        is_r, is_md, is_un, is_addi, is_ld, is_st;
  logic        go, wait_st, timed_out;
  logic        unused_c;

  assign op      = ir[31:27];
  assign ra_oh   = 16'(1) << ir[26:23];
  assign rb_oh   = 16'(1) << ir[22:19];
  assign rc_oh   = 16'(1) << ir[18:15];
  assign alu_op  = 13'(1) << op;
  assign unused_c = ^ir[14:0];

  assign is_r    = (op <= 5'd8);
  assign is_md   = (op == 5'd9) || (op == 5'd10);
  assign is_un   = (op == 5'd11) || (op == 5'd12);
  assign is_addi = (op == 5'd13);
  assign is_ld   = (op == 5'd14);
  assign is_st   = (op == 5'd15);

`ifdef SINGLE_STEP_EN
  assign go = run & step;
`else
  assign go = run;
`endif

  assign wait_st   = (state == T1) || (state == T6 && is_ld) || (state == T7 && is_st);
  assign timed_out = (MEM_TIMEOUT != 0) && wait_st && !mem_ready && (wait_cnt == TO_LAST);

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= T0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (wait_st && state_nx == state) ? wait_cnt + CW'(1) : '0;
      if (timed_out) err <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      T0: if (go) state_nx = T1;
      T1: if (timed_out) state_nx = HALT; else if (mem_ready) state_nx = T2;
      T2: state_nx = T3;
      T3: begin
        if (is_r || is_md || is_un || is_addi || is_ld || is_st) state_nx = T4;
        else if (op == 5'd31)                                    state_nx = HALT;
        else                                                     state_nx = T0;
      end
      T4: state_nx = is_un ? T0 : T5;
      T5: state_nx = (is_md || is_ld || is_st) ? T6 : T0;
      T6: begin
        if (is_ld)      state_nx = timed_out ? HALT : (mem_ready ? T7 : T6);
        else if (is_st) state_nx = T7;
        else            state_nx = T0;
      end
      T7: begin
        if (is_st) state_nx = timed_out ? HALT : (mem_ready ? T0 : T7);
        else       state_nx = T0;
      end
      HALT:    state_nx = HALT;
      default: state_nx = T0;
    endcase
  end

  always_comb begin
    ctl             = '0;
    ctl.halted      = (state == HALT);
    ctl.timeout_err = err;
    case (state)
      T0: if (go) begin
        ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.zlow_in = 1'b1;
      end
      T1: begin
        ctl.zlow_out = 1'b1; ctl.pc_in = 1'b1; ctl.mem_read = 1'b1;
        ctl.md_mux_read = 1'b1; ctl.mdr_in = mem_ready;
      end
      T2: begin ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1; end
      T3: begin
        if (is_md) begin
          ctl.reg_out = ra_oh; ctl.y_in = 1'b1;
        end else if (is_un) begin
          ctl.reg_out = rb_oh; ctl.alu_sel = alu_op; ctl.zlow_in = 1'b1;
        end else if (is_r || is_addi || is_ld || is_st) begin
          ctl.reg_out = rb_oh; ctl.y_in = 1'b1;
        end
      end
      T4: begin
        if (is_r) begin
          ctl.reg_out = rc_oh; ctl.alu_sel = alu_op; ctl.zlow_in = 1'b1;
        end else if (is_md) begin
          ctl.reg_out = rb_oh; ctl.alu_sel = alu_op; ctl.zhigh_in = 1'b1; ctl.zlow_in = 1'b1;
        end else if (is_un) begin
          ctl.zlow_out = 1'b1; ctl.reg_in = ra_oh;
        end else begin
          // addi, ld and st share the base+offset add
          ctl.cse_out = 1'b1; ctl.alu_sel = 13'd1; ctl.zlow_in = 1'b1;
        end
      end
      T5: begin
        ctl.zlow_out = 1'b1;
        if (is_md)              ctl.lo_in  = 1'b1;
        else if (is_ld || is_st) ctl.mar_in = 1'b1;
        else                    ctl.reg_in = ra_oh;
      end
      T6: begin
        if (is_md) begin
          ctl.zhigh_out = 1'b1; ctl.hi_in = 1'b1;
        end else if (is_ld) begin
          ctl.mem_read = 1'b1; ctl.md_mux_read = 1'b1; ctl.mdr_in = mem_ready;
        end else if (is_st) begin
          ctl.reg_out = ra_oh; ctl.mdr_in = 1'b1;
        end
      end
      T7: begin
        if (is_ld) begin
          ctl.mdr_out = 1'b1; ctl.reg_in = ra_oh;
        end else if (is_st) begin
          ctl.mem_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // clear silences every output in the cycle it is asserted
  assign ctl_q = clear ? '0 : ctl;
  assign {reg_in, reg_out, hi_in, lo_in, hi_out, lo_out, zhigh_in, zlow_in, zhigh_out,
          zlow_out, pc_in, pc_out, mdr_in, mdr_out, mar_in, ir_in, y_in, cse_out,
          md_mux_read, alu_sel, inc_pc, mem_read, mem_write, halted, timeout_err} = ctl_q;

endmodule
